// File: rtl/key_pkg.sv
// Shared definitions for the key event queue: key/code widths, the
// queued event record and a priority helper that picks the lowest key.
package key_pkg;

  localparam int KEY_N  = 8;
  localparam int CODE_W = 3;

  // One queued event: which key, and whether it is an auto-repeat.
  typedef struct packed {
    logic              rpt;
    logic [CODE_W-1:0] code;
  } key_event_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [CODE_W-1:0] lowest_set(input logic [KEY_N-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered storage array. The head entry
// is read straight out of the storage registers, so it stays put while the
// consumer stalls. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns debounced key levels into a queue of discrete key events.
// Presses are collected into a pending set and drained one per cycle,
// lowest key first, so simultaneous presses and presses made while the
// FIFO is full are not lost. A held key produces auto-repeat events once
// the FIFO has room and no fresh press is waiting.
module key_event_queue
  import key_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [KEY_N-1:0]       key_in,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [CODE_W-1:0]      ev_code,
  output logic                   ev_repeat,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W    = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int DELAY_M1 = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int RELOAD   = (REPEAT_DELAY > 0) ? REPEAT_DELAY - REPEAT_PERIOD : 0;

  logic [KEY_N-1:0]  prev;
  logic [KEY_N-1:0]  pend;
  logic [KEY_N-1:0]  rise;
  logic [KEY_N-1:0]  cand;
  logic [KEY_N-1:0]  press_mask;
  logic [KEY_N-1:0]  pend_next;
  logic [CODE_W-1:0] press_code;
  logic [CODE_W-1:0] hk;
  logic [CODE_W-1:0] hk_prev;
  logic [CNT_W-1:0]  hold_cnt;
  logic              rpt_req;
  logic              hold_same;
  logic              expire;
  logic              pop;
  logic              push_ok;
  logic              press_push;
  logic              rpt_push;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  key_event_t        wr_event;
  key_event_t        head_event;

  assign rise       = key_in & ~prev;
  assign cand       = pend | rise;
  assign press_code = lowest_set(cand);
  assign press_mask = KEY_N'(1) << press_code;
  assign hk         = lowest_set(key_in);

  // A key counts as "still held" only if some key was down last cycle too
  // and the lowest held key has not changed; anything else restarts timing.
  assign hold_same  = (|key_in) && (|prev) && (hk == hk_prev);
  assign expire     = (REPEAT_DELAY > 0) && hold_same && (hold_cnt == CNT_W'(DELAY_M1));

  assign pop        = ev_valid && ev_ready;
  assign push_ok    = !fifo_full || pop;
  assign press_push = (|cand) && push_ok;
  assign rpt_push   = !(|cand) && rpt_req && hold_same && push_ok;
  assign push       = press_push || rpt_push;

  // Choose what to enqueue this cycle; fresh presses beat auto-repeats.
  always_comb begin
    wr_event      = '0;
    pend_next     = cand;
    if (press_push) begin
      wr_event.rpt  = 1'b0;
      wr_event.code = press_code;
      pend_next     = cand & ~press_mask;
    end else if (rpt_push) begin
      wr_event.rpt  = 1'b1;
      wr_event.code = hk;
    end
  end

  // Edge detection history and pending presses; prev starts all-ones so
  // keys already down when reset lifts are not reported as presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '1;
      pend <= '0;
    end else begin
      prev <= key_in;
      pend <= pend_next;
    end
  end

  // A second press of a key whose first press is still pending is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (|(rise & pend)) begin
      overflow <= 1'b1;
    end
  end

  // Hold timer and repeat request for the lowest held key. An expiry while
  // a request is still outstanding simply re-arms the same request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      rpt_req  <= 1'b0;
      hk_prev  <= '0;
    end else begin
      hk_prev <= hk;
      if (!hold_same) begin
        hold_cnt <= '0;
        rpt_req  <= 1'b0;
      end else if (expire) begin
        hold_cnt <= CNT_W'(RELOAD);
        rpt_req  <= 1'b1;
      end else begin
        if (REPEAT_DELAY > 0) hold_cnt <= hold_cnt + 1'b1;
        if (rpt_push) rpt_req <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(key_event_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_event),
    .head  (head_event),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_code   = head_event.code;
  assign ev_repeat = head_event.rpt;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with DEPTH=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=4. Inputs change 1 ns after each rising edge and outputs
// are sampled at the same point, so each check sees the state left by the
// edge that just happened.
module tb_key_event_queue;

  logic       clk;
  logic       rst;
  logic [7:0] key_in;
  logic       ev_ready;
  logic       ev_valid;
  logic [2:0] ev_code;
  logic       ev_repeat;
  logic       overflow;
  logic [2:0] count;

  int checks;
  int errors;

  key_event_queue #(
    .DEPTH         (4),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_repeat (ev_repeat),
    .overflow  (overflow),
    .count     (count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and step 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive keys and ready, then take one edge.
  task automatic applyStimulus(input logic [7:0] keys, input logic ready);
    key_in   = keys;
    ev_ready = ready;
    tick();
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Whole directed sequence, ending with the summary line.
  initial begin
    logic exp_v;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    key_in   = 8'h01;
    ev_ready = 1'b1;

    // Reset with key 0 held: nothing queued, nothing reported afterwards.
    tick();
    tick();
    checkOutput("rst_valid", {7'b0, ev_valid}, 8'h00);
    checkOutput("rst_count", {5'b0, count}, 8'h00);
    checkOutput("rst_code", {5'b0, ev_code}, 8'h00);
    checkOutput("rst_repeat", {7'b0, ev_repeat}, 8'h00);
    checkOutput("rst_overflow", {7'b0, overflow}, 8'h00);
    rst = 1'b0;
    applyStimulus(8'h01, 1'b1);
    checkOutput("held_no_press_a", {7'b0, ev_valid}, 8'h00);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h01, 1'b1);
    checkOutput("held_no_press_b", {5'b0, count}, 8'h00);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);

    // Keys 2 and 5 rise together: code 2 first, then code 5.
    applyStimulus(8'h24, 1'b0);
    checkOutput("multi_valid", {7'b0, ev_valid}, 8'h01);
    checkOutput("multi_code_a", {5'b0, ev_code}, 8'h02);
    checkOutput("multi_repeat_a", {7'b0, ev_repeat}, 8'h00);
    checkOutput("multi_count_a", {5'b0, count}, 8'h01);
    applyStimulus(8'h24, 1'b0);
    checkOutput("multi_count_b", {5'b0, count}, 8'h02);
    checkOutput("multi_head_hold", {5'b0, ev_code}, 8'h02);
    applyStimulus(8'h00, 1'b0);
    checkOutput("multi_count_c", {5'b0, count}, 8'h02);
    applyStimulus(8'h00, 1'b1);
    checkOutput("multi_code_b", {5'b0, ev_code}, 8'h05);
    checkOutput("multi_repeat_b", {7'b0, ev_repeat}, 8'h00);
    checkOutput("multi_count_d", {5'b0, count}, 8'h01);
    applyStimulus(8'h00, 1'b1);
    checkOutput("multi_drained", {7'b0, ev_valid}, 8'h00);

    // Hold key 3: press, then repeats at edges 9, 13 and 17 after it.
    applyStimulus(8'h08, 1'b1);
    checkOutput("hold_press_valid", {7'b0, ev_valid}, 8'h01);
    checkOutput("hold_press_code", {5'b0, ev_code}, 8'h03);
    checkOutput("hold_press_repeat", {7'b0, ev_repeat}, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(8'h08, 1'b1);
      exp_v = (i == 9) || (i == 13) || (i == 17);
      checkOutput($sformatf("hold_valid_%0d", i), {7'b0, ev_valid}, {7'b0, exp_v});
      if (exp_v) begin
        checkOutput($sformatf("hold_code_%0d", i), {5'b0, ev_code}, 8'h03);
        checkOutput($sformatf("hold_repeat_%0d", i), {7'b0, ev_repeat}, 8'h01);
      end
    end
    applyStimulus(8'h00, 1'b1);
    checkOutput("hold_release", {7'b0, ev_valid}, 8'h00);

    // Stalled consumer, keys 0..5 one per cycle: count saturates at 4.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(8'h01 << k, 1'b0);
      checkOutput($sformatf("fill_count_%0d", k), {5'b0, count},
                  (k < 4) ? 8'(k + 1) : 8'h04);
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("fill_head", {5'b0, ev_code}, 8'h00);

    // Key 6 pressed, released and pressed again while still pending.
    applyStimulus(8'h40, 1'b0);
    checkOutput("ovf_first_press", {7'b0, overflow}, 8'h00);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h40, 1'b0);
    checkOutput("ovf_set", {7'b0, overflow}, 8'h01);
    checkOutput("ovf_count", {5'b0, count}, 8'h04);
    applyStimulus(8'h00, 1'b0);

    // Drain: heads 1..6 in order, key 6 only once, then empty.
    for (int d = 1; d <= 6; d++) begin
      applyStimulus(8'h00, 1'b1);
      checkOutput($sformatf("drain_code_%0d", d), {5'b0, ev_code}, 8'(d));
      checkOutput($sformatf("drain_repeat_%0d", d), {7'b0, ev_repeat}, 8'h00);
    end
    applyStimulus(8'h00, 1'b1);
    checkOutput("drain_empty_valid", {7'b0, ev_valid}, 8'h00);
    checkOutput("drain_empty_count", {5'b0, count}, 8'h00);
    checkOutput("ovf_sticky", {7'b0, overflow}, 8'h01);

    // Reset with three events queued discards everything.
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h04, 1'b0);
    key_in = 8'h00;
    checkOutput("mid_count_before", {5'b0, count}, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_count", {5'b0, count}, 8'h00);
    checkOutput("mid_rst_valid", {7'b0, ev_valid}, 8'h00);
    checkOutput("mid_rst_overflow", {7'b0, overflow}, 8'h00);
    applyStimulus(8'h00, 1'b1);
    checkOutput("mid_rst_after", {7'b0, ev_valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
